// File: rtl/mem_dump.sv
// mem_dump: sample-memory readout engine.
// On activate, reads every RAM word once starting at start_addr (wrapping),
// and streams each word to the UART transmitter least-significant byte first.
module mem_dump #(
  parameter int SAMPLE_DEPTH = 8,
  parameter int WIDTH        = 8
) (
  input  logic                    clk_50mhz,
  input  logic                    reset,
  input  logic                    activate,
  output logic                    done,
  input  logic [SAMPLE_DEPTH-1:0] start_addr,
  output logic                    mem_clk,
  output logic [SAMPLE_DEPTH-1:0] mem_addr,
  output logic                    mem_we,
  input  logic [WIDTH-1:0]        mem_data,
  output logic [7:0]              tx_data,
  output logic                    tx_start,
  input  logic                    tx_busy
);

  // Bytes sent per word, and the width of the zero-padded shift register.
  localparam int BYTES = (WIDTH + 7) / 8;
  localparam int SHW   = BYTES * 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  // One extra bit so a full-memory word count is representable.
  localparam int CNT_W = SAMPLE_DEPTH + 1;
  localparam logic [CNT_W-1:0] FULL     = {1'b1, {SAMPLE_DEPTH{1'b0}}};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LOAD,
    SEND,
    GUARD,
    TXWAIT,
    DONE
  } state_t;

  state_t                  state, state_next;
  logic [SAMPLE_DEPTH-1:0] addr_next;
  logic [CNT_W-1:0]        word_cnt, word_cnt_next, word_cnt_inc;
  logic [IDX_W-1:0]        byte_idx, byte_idx_next;
  logic [SHW-1:0]          shift_reg, shift_next;
  logic [7:0]              tx_data_next;
  logic                    tx_start_next;
  logic                    done_next;
  // Remembers that activate fell after a byte was launched, so the dump
  // stops once that byte has finished instead of reading the next word.
  logic                    abort, abort_next;

  // The RAM runs on the system clock and is never written by this engine.
  assign mem_clk      = clk_50mhz;
  assign mem_we       = 1'b0;
  assign word_cnt_inc = word_cnt + 1'b1;

  // Next-state and next-datapath logic for the readout sequence.
  always_comb begin
    state_next    = state;
    addr_next     = mem_addr;
    word_cnt_next = word_cnt;
    byte_idx_next = byte_idx;
    shift_next    = shift_reg;
    tx_data_next  = tx_data;
    tx_start_next = 1'b0;
    done_next     = done;
    abort_next    = abort;

    case (state)
      IDLE: begin
        done_next  = 1'b0;
        abort_next = 1'b0;
        if (activate) begin
          addr_next     = start_addr;
          word_cnt_next = '0;
          state_next    = READ;
        end
      end

      READ: begin
        state_next = activate ? LOAD : IDLE;
      end

      LOAD: begin
        if (!activate) begin
          state_next = IDLE;
        end else begin
          shift_next              = '0;
          shift_next[WIDTH-1:0]   = mem_data;
          byte_idx_next           = '0;
          state_next              = SEND;
        end
      end

      SEND: begin
        if (!activate) begin
          state_next = IDLE;
        end else if (!tx_busy) begin
          tx_data_next  = shift_reg[7:0];
          tx_start_next = 1'b1;
          state_next    = GUARD;
        end
      end

      GUARD: begin
        if (!activate) begin
          abort_next = 1'b1;
        end
        state_next = TXWAIT;
      end

      TXWAIT: begin
        if (!activate) begin
          abort_next = 1'b1;
        end
        if (!tx_busy) begin
          shift_next = shift_reg >> 8;
          if (byte_idx != LAST_IDX) begin
            byte_idx_next = byte_idx + 1'b1;
            state_next    = SEND;
          end else begin
            word_cnt_next = word_cnt_inc;
            addr_next     = mem_addr + 1'b1;
            if (word_cnt_inc == FULL) begin
              state_next = DONE;
              done_next  = 1'b1;
            end else begin
              state_next = READ;
            end
          end
          if (abort || !activate) begin
            state_next = IDLE;
            done_next  = 1'b0;
          end
        end
      end

      DONE: begin
        if (!activate) begin
          done_next  = 1'b0;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drives every output to its idle value.
  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mem_addr  <= '0;
      word_cnt  <= '0;
      byte_idx  <= '0;
      shift_reg <= '0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      done      <= 1'b0;
      abort     <= 1'b0;
    end else begin
      state     <= state_next;
      mem_addr  <= addr_next;
      word_cnt  <= word_cnt_next;
      byte_idx  <= byte_idx_next;
      shift_reg <= shift_next;
      tx_data   <= tx_data_next;
      tx_start  <= tx_start_next;
      done      <= done_next;
      abort     <= abort_next;
    end
  end

endmodule

// File: tb/tb_mem_dump.sv
// tb_mem_dump: scoreboard bench for mem_dump.
// Two instances: default 8x256 and a 12-bit x 4-word variant that exercises
// multi-byte words and top-byte padding. Expected bytes come from a simple
// walk over the RAM contents and are popped by per-instance monitors.
module tb_mem_dump;

  localparam int DA = 8;
  localparam int WA = 8;
  localparam int DB = 2;
  localparam int WB = 12;

  logic clk = 1'b0;
  logic reset;

  // Instance A signals
  logic          act_a, done_a, mem_clk_a, mem_we_a, tx_start_a, tx_busy_a;
  logic [DA-1:0] start_addr_a, mem_addr_a;
  logic [WA-1:0] mem_data_a;
  logic [7:0]    tx_data_a;

  // Instance B signals
  logic          act_b, done_b, mem_clk_b, mem_we_b, tx_start_b, tx_busy_b;
  logic [DB-1:0] start_addr_b, mem_addr_b;
  logic [WB-1:0] mem_data_b;
  logic [7:0]    tx_data_b;

  logic [WA-1:0] ram_a [0:(1<<DA)-1];
  logic [WB-1:0] ram_b [0:(1<<DB)-1];

  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];

  int total = 0;
  int bad = 0;
  int pulses_a = 0;
  int pulses_b = 0;
  int busy_cnt_a = 0;
  int busy_cnt_b = 0;
  int overlap_a = 0;
  int overlap_b = 0;
  logic hold_a = 1'b0;
  logic we_seen = 1'b0;

  always #5 clk = ~clk;

  mem_dump #(.SAMPLE_DEPTH(DA), .WIDTH(WA)) u_dut_a (
    .clk_50mhz (clk),
    .reset     (reset),
    .activate  (act_a),
    .done      (done_a),
    .start_addr(start_addr_a),
    .mem_clk   (mem_clk_a),
    .mem_addr  (mem_addr_a),
    .mem_we    (mem_we_a),
    .mem_data  (mem_data_a),
    .tx_data   (tx_data_a),
    .tx_start  (tx_start_a),
    .tx_busy   (tx_busy_a)
  );

  mem_dump #(.SAMPLE_DEPTH(DB), .WIDTH(WB)) u_dut_b (
    .clk_50mhz (clk),
    .reset     (reset),
    .activate  (act_b),
    .done      (done_b),
    .start_addr(start_addr_b),
    .mem_clk   (mem_clk_b),
    .mem_addr  (mem_addr_b),
    .mem_we    (mem_we_b),
    .mem_data  (mem_data_b),
    .tx_data   (tx_data_b),
    .tx_start  (tx_start_b),
    .tx_busy   (tx_busy_b)
  );

  // Synchronous-read RAM models: data appears one edge after the address.
  always @(posedge clk) begin
    mem_data_a <= ram_a[mem_addr_a];
    mem_data_b <= ram_b[mem_addr_b];
  end

  // Transmitter models: a launch starts a random busy period; a launch
  // while already busy is recorded as an overlap.
  always @(negedge clk) begin
    if (tx_start_a && (busy_cnt_a != 0 || hold_a)) overlap_a++;
    if (tx_start_a && busy_cnt_a == 0) busy_cnt_a = $urandom_range(10, 3);
    else if (busy_cnt_a > 0) busy_cnt_a = busy_cnt_a - 1;
    if (tx_start_b && busy_cnt_b != 0) overlap_b++;
    if (tx_start_b && busy_cnt_b == 0) busy_cnt_b = $urandom_range(10, 3);
    else if (busy_cnt_b > 0) busy_cnt_b = busy_cnt_b - 1;
  end

  assign tx_busy_a = (busy_cnt_a != 0) || hold_a;
  assign tx_busy_b = (busy_cnt_b != 0);

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every launched byte is popped off the scoreboard and compared.
  always @(negedge clk) begin
    logic [7:0] e;
    if (reset && tx_start_a) begin
      pulses_a++;
      if (exp_a.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL extra_pulse_a: got byte 0x%0h, want no pulse", tx_data_a);
      end else begin
        e = exp_a.pop_front();
        check_output("byte_a", 32'(tx_data_a), 32'(e));
      end
    end
    if (reset && tx_start_b) begin
      pulses_b++;
      if (exp_b.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL extra_pulse_b: got byte 0x%0h, want no pulse", tx_data_b);
      end else begin
        e = exp_b.pop_front();
        check_output("byte_b", 32'(tx_data_b), 32'(e));
      end
    end
    if (mem_we_a || mem_we_b) we_seen = 1'b1;
  end

  // Reference model: every word once from s, wrapping, low byte first.
  task automatic push_expected_a(input logic [DA-1:0] s);
    for (int k = 0; k < (1 << DA); k++) begin
      logic [DA-1:0] a;
      a = s + DA'(k);
      exp_a.push_back(ram_a[a]);
    end
  endtask

  task automatic push_expected_b(input logic [DB-1:0] s);
    for (int k = 0; k < (1 << DB); k++) begin
      logic [DB-1:0] a;
      logic [15:0]   w;
      a = s + DB'(k);
      w = 16'(ram_b[a]);
      exp_b.push_back(w[7:0]);
      exp_b.push_back(w[15:8]);
    end
  endtask

  task automatic wait_pulses_a(input int target, input int budget);
    int n = 0;
    while (pulses_a < target && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    check_output("pulse_wait_a", 32'(pulses_a >= target), 32'd1);
  endtask

  task automatic wait_done_a(input int budget);
    int n = 0;
    while (!done_a && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output("done_a_rises", 32'(done_a), 32'd1);
  endtask

  task automatic wait_done_b(input int budget);
    int n = 0;
    while (!done_b && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output("done_b_rises", 32'(done_b), 32'd1);
  endtask

  // Completion checks for a full dump on A, then the done/activate handshake.
  task automatic finish_full_a(input string tag);
    wait_done_a(20000);
    check_output({tag, "_count"}, 32'(pulses_a), 32'(1 << DA));
    check_output({tag, "_left"}, 32'(exp_a.size()), 32'd0);
    repeat (3) @(negedge clk);
    check_output({tag, "_done_held"}, 32'(done_a), 32'd1);
    act_a = 1'b0;
    @(negedge clk);
    check_output({tag, "_done_falls"}, 32'(done_a), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic apply_stimulus_a(input logic [DA-1:0] s, input int hold, input string tag);
    push_expected_a(s);
    pulses_a = 0;
    start_addr_a = s;
    hold_a = (hold > 0);
    @(negedge clk);
    act_a = 1'b1;
    repeat (2) @(negedge clk);
    start_addr_a = ~s;
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check_output({tag, "_no_pulse_while_busy"}, 32'(pulses_a), 32'd0);
      hold_a = 1'b0;
    end
    finish_full_a(tag);
  endtask

  task automatic run_b(input logic [DB-1:0] s, input string tag);
    pulses_b = 0;
    start_addr_b = s;
    @(negedge clk);
    act_b = 1'b1;
    wait_done_b(2000);
    check_output({tag, "_count"}, 32'(pulses_b), 32'd8);
    check_output({tag, "_left"}, 32'(exp_b.size()), 32'd0);
    act_b = 1'b0;
    @(negedge clk);
    check_output({tag, "_done_falls"}, 32'(done_b), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got no completion, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    logic [DA-1:0] s;
    reset = 1'b0;
    act_a = 1'b0;
    act_b = 1'b0;
    start_addr_a = '0;
    start_addr_b = '0;
    for (int i = 0; i < (1 << DA); i++) ram_a[i] = DA'(i);
    for (int i = 0; i < (1 << DB); i++) ram_b[i] = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check_output("rst_done", 32'(done_a), 32'd0);
    check_output("rst_tx_start", 32'(tx_start_a), 32'd0);
    check_output("rst_tx_data", 32'(tx_data_a), 32'd0);
    check_output("rst_mem_addr", 32'(mem_addr_a), 32'd0);
    check_output("rst_mem_we", 32'(mem_we_a), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_output("mem_clk_low", 32'(mem_clk_a), 32'd0);
    @(posedge clk);
    #1;
    check_output("mem_clk_high", 32'(mem_clk_a), 32'd1);

    // Identity RAM from address 0, with first-byte latency measured
    push_expected_a('0);
    pulses_a = 0;
    start_addr_a = '0;
    @(negedge clk);
    act_a = 1'b1;
    lat = 0;
    while (!tx_start_a && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check_output("first_byte_latency", 32'(lat), 32'd4);
    start_addr_a = 8'h5A;
    finish_full_a("ident_start0");

    // Wrap from 0xFE over random contents
    for (int i = 0; i < (1 << DA); i++) ram_a[i] = 8'($urandom);
    apply_stimulus_a(8'hFE, 0, "wrap_fe");

    // Transmitter held busy for 50 cycles at start
    for (int i = 0; i < (1 << DA); i++) ram_a[i] = 8'($urandom);
    apply_stimulus_a(8'($urandom), 50, "busy_hold");

    // Abort during byte 5, then restart from a new address
    for (int i = 0; i < (1 << DA); i++) ram_a[i] = 8'($urandom);
    s = 8'($urandom);
    for (int k = 0; k < 5; k++) begin
      logic [DA-1:0] a;
      a = s + DA'(k);
      exp_a.push_back(ram_a[a]);
    end
    pulses_a = 0;
    start_addr_a = s;
    @(negedge clk);
    act_a = 1'b1;
    wait_pulses_a(5, 2000);
    act_a = 1'b0;
    repeat (40) @(negedge clk);
    check_output("abort_pulses", 32'(pulses_a), 32'd5);
    check_output("abort_done", 32'(done_a), 32'd0);
    apply_stimulus_a(s + 8'd77, 0, "after_abort");

    // Reset while waiting on the transmitter, then a fresh dump
    for (int i = 0; i < (1 << DA); i++) ram_a[i] = 8'($urandom);
    s = 8'($urandom_range(200, 1));
    push_expected_a(s);
    pulses_a = 0;
    start_addr_a = s;
    @(negedge clk);
    act_a = 1'b1;
    wait_pulses_a(20, 5000);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("midrst_tx_start", 32'(tx_start_a), 32'd0);
    check_output("midrst_done", 32'(done_a), 32'd0);
    check_output("midrst_mem_addr", 32'(mem_addr_a), 32'd0);
    check_output("midrst_tx_data", 32'(tx_data_a), 32'd0);
    exp_a.delete();
    act_a = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    apply_stimulus_a(8'($urandom), 0, "after_reset");

    // 12-bit words: fixed contents with hand-written byte stream
    ram_b[0] = 12'hABC;
    ram_b[1] = 12'h123;
    ram_b[2] = 12'hFFF;
    ram_b[3] = 12'h000;
    exp_b.push_back(8'hBC); exp_b.push_back(8'h0A);
    exp_b.push_back(8'h23); exp_b.push_back(8'h01);
    exp_b.push_back(8'hFF); exp_b.push_back(8'h0F);
    exp_b.push_back(8'h00); exp_b.push_back(8'h00);
    run_b(2'd0, "w12_fixed");

    // 12-bit words: random contents and start
    for (int r = 0; r < 3; r++) begin
      logic [DB-1:0] sb;
      for (int i = 0; i < (1 << DB); i++) ram_b[i] = 12'($urandom);
      sb = 2'($urandom);
      push_expected_b(sb);
      run_b(sb, "w12_random");
    end

    check_output("mem_we_never", 32'(we_seen), 32'd0);
    check_output("no_overlap_a", 32'(overlap_a), 32'd0);
    check_output("no_overlap_b", 32'(overlap_b), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_dump.md
# mem_dump

Sample-memory readout engine: on `activate`, reads every word of the sample RAM once, starting from a given address and wrapping around, and streams each word to the UART transmitter one byte at a time. It is the transmit-side counterpart of the host-command memory fill path. It shares the sample-RAM port and the `activate`/`done` handshake with the other command modules and is selected by the same top-level command decoder.

## Interface

Parameters:
- `SAMPLE_DEPTH`, 8: address width; the RAM holds 2^SAMPLE_DEPTH words.
- `WIDTH`, 8: word width in bits; BYTES = ceil(WIDTH/8) bytes are sent per word.

Ports:
- `clk_50mhz` in 1: single system clock; every register is clocked on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `activate` in 1: level request from the command decoder.
- `done` out 1: high after the last byte has been handed off; held until `activate` falls.
- `start_addr` in SAMPLE_DEPTH: first address to read (circular-buffer oldest sample); latched at start.
- `mem_clk` out 1: equal to `clk_50mhz`; never gated.
- `mem_addr` out SAMPLE_DEPTH: read address.
- `mem_we` out 1: constant 0.
- `mem_data` in WIDTH: RAM read data, valid on the first rising edge after `mem_addr` is presented (one-cycle synchronous read).
- `tx_data` out 8: byte to transmit.
- `tx_start` out 1: one-cycle pulse that launches a byte.
- `tx_busy` in 1: transmitter busy; rises on the cycle after `tx_start` and falls when the stop bit ends.

## Operation

- Reset values: `done`=0, `tx_start`=0, `tx_data`=0, `mem_addr`=0, `mem_we`=0; state IDLE; word counter and byte index 0.
- IDLE: if `activate`=1, latch `start_addr` into `mem_addr`, clear the word counter, and go to READ.
- READ: wait one cycle for the RAM. Go to LOAD.
- LOAD: capture `mem_data` into the word shift register, zero-extended to BYTES×8 bits. Set byte index to 0. Go to SEND.
- SEND: if `tx_busy`=0, drive `tx_data` with the low byte of the shift register, pulse `tx_start` for one cycle, and go to GUARD. Otherwise stay in SEND.
- GUARD: one cycle in which `tx_busy` is ignored, covering the transmitter's busy latency. Go to TXWAIT.
- TXWAIT: wait for `tx_busy`=0. Then:
  - Shift the register right by 8 and increment the byte index.
  - If the index is below BYTES, go to SEND.
  - Otherwise increment the word counter and `mem_addr`. `mem_addr` wraps modulo 2^SAMPLE_DEPTH.
  - If the word counter reaches 2^SAMPLE_DEPTH, go to DONE; else go to READ.
- DONE: `done`=1. When `activate`=0, clear `done` and go to IDLE.
- Byte order is little-endian: the least-significant byte of each word is sent first. Pad bits in the top byte are 0.
- Abort rule: if `activate` falls in any busy state (READ through TXWAIT):
  - The byte already launched completes; the module leaves TXWAIT normally but then goes to IDLE.
  - No further `tx_start` is issued, and `done` stays 0.
  - A fall in READ, LOAD or SEND before the pulse goes directly to IDLE.
- The word counter is SAMPLE_DEPTH+1 bits wide so that a full-memory count is representable.
- `start_addr` changes after the latch have no effect.

## Timing

- Edge numbering: edge 0 is the edge at which IDLE samples `activate`=1. At edge 0 `mem_addr` takes `start_addr`; READ runs edge 0→1; LOAD captures `mem_data` at edge 2; SEND registers the pulse at edge 3.
- First byte latency: with `tx_busy`=0, `tx_start` is high from edge 3 to edge 4.
- Inter-byte gap: the next `tx_start` is at least 2 cycles after `tx_busy` falls, more if a new word must be read.
- Throughput is bounded by the UART, never by the RAM.
- Total pulses per full dump: 2^SAMPLE_DEPTH × BYTES.
- `done` rises on the cycle after the final TXWAIT exit and falls on the cycle after `activate`=0 is sampled.
- Reset asserted mid-dump forces all outputs to their reset values immediately; a `tx_start` pulse may be cut short.

## Test plan

- Default parameters, RAM[i]=i, `start_addr`=0, a model transmitter with a 10-cycle busy period → 256 `tx_start` pulses carrying 0x00…0xFF in order; `done`=1; `mem_we` never high.
- `start_addr`=0xFE → byte sequence 0xFE, 0xFF, 0x00, …, 0xFD; exactly 256 bytes.
- `WIDTH`=12, `SAMPLE_DEPTH`=2, RAM = {0xABC, 0x123, 0xFFF, 0x000} → bytes BC 0A 23 01 FF 0F 00 00.
- `tx_busy` held high for 50 cycles at start → no `tx_start` until it falls; the first pulse follows, and no byte is lost or duplicated.
- `activate` dropped during the busy period of byte 5 → byte 5 completes, no sixth pulse, `done` stays 0, state returns to IDLE; a new `activate` restarts from the newly latched `start_addr`.
- `reset` asserted (low) in TXWAIT → `tx_start`=0, `done`=0, `mem_addr`=0 immediately; after release, a fresh dump runs correctly.
